// File: rtl/gray_ptr_gen.sv
// Registered binary pointer with a flop-direct Gray copy for clock-domain crossing.
// Define GRAY_CHECK_EN to compile in the sticky single-step checker (step_err).
module gray_ptr_gen #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  output logic [WIDTH-1:0] bin_q,
  output logic [WIDTH-1:0] gray_q,
  output logic [WIDTH-1:0] gray_nxt,
  output logic             wrap,
  output logic             step_err
);

  logic [WIDTH-1:0] bin_d;
  logic             inc_win;
  logic             wrap_d;

  // Next pointer by priority: clear, load, increment, hold
  always_comb begin
    bin_d   = bin_q;
    inc_win = 1'b0;
    if (clr) begin
      bin_d = '0;
    end else if (load) begin
      bin_d = load_val;
    end else if (inc) begin
      bin_d   = bin_q + WIDTH'(1);
      inc_win = 1'b1;
    end
  end

  assign gray_nxt = bin_d ^ (bin_d >> 1);
  assign wrap_d   = inc_win & (&bin_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap   <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_nxt;
      wrap   <= wrap_d;
    end
  end

`ifdef GRAY_CHECK_EN
  logic [WIDTH-1:0] gray_diff;
  logic             step_bad;

  // An increment must flip exactly one Gray bit: diff nonzero and a power of two
  assign gray_diff = gray_nxt ^ gray_q;
  assign step_bad  = inc_win &
                     ((gray_diff == '0) || ((gray_diff & (gray_diff - WIDTH'(1))) != '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_err <= 1'b0;
    end else if (step_bad) begin
      step_err <= 1'b1;
    end
  end
`else
  assign step_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_ptr_gen.sv
// Self-checking bench for gray_ptr_gen: directed WIDTH=4 steps, random ops, WIDTH=8 long run.
module tb_gray_ptr_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       clr4 = 1'b0, load4 = 1'b0, inc4 = 1'b0;
  logic [3:0] lv4 = '0;
  logic [3:0] b4, g4, gn4;
  logic       w4, se4;

  logic       clr8 = 1'b0, load8 = 1'b0, inc8 = 1'b0;
  logic [7:0] lv8 = '0;
  logic [7:0] b8, g8, gn8;
  logic       w8, se8;

  gray_ptr_gen #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .clr(clr4), .load(load4), .load_val(lv4), .inc(inc4),
    .bin_q(b4), .gray_q(g4), .gray_nxt(gn4), .wrap(w4), .step_err(se4)
  );

  gray_ptr_gen #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .clr(clr8), .load(load8), .load_val(lv8), .inc(inc8),
    .bin_q(b8), .gray_q(g8), .gray_nxt(gn8), .wrap(w8), .step_err(se8)
  );

  int checks = 0;
  int failures = 0;

  // Reflected Gray code sequence for 4 bits, indexed by binary value
  int gray_tbl [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                        4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Gray-to-binary decode (prefix XOR from the MSB)
  function automatic int gdec8(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return int'(b);
  endfunction

  int m4;
  int m8;
  int wraps8;
  logic [3:0] prev4;
  logic [7:0] prev8;
  bit exp_w;

  initial begin
    // Reset held for 3 cycles
    repeat (3) cyc();
    chk("rst_bin", 32'(b4), 0);
    chk("rst_gray", 32'(g4), 0);
    chk("rst_wrap", 32'(w4), 0);
    chk("rst_err", 32'(se4), 0);
    chk("rst_gnxt", 32'(gn4), 0);
    chk("rst_bin8", 32'(b8), 0);
    rst_n = 1'b1;
    m4 = 0;

    // 16 consecutive increments around the full code space
    for (int k = 0; k < 16; k++) begin
      inc4 = 1'b1;
      #1;
      chk("inc_gnxt", 32'(gn4), 32'(gray_tbl[(m4 + 1) % 16]));
      prev4 = g4;
      exp_w = (m4 == 15);
      cyc();
      m4 = (m4 + 1) % 16;
      chk("inc_bin", 32'(b4), 32'(m4));
      chk("inc_gray", 32'(g4), 32'(gray_tbl[m4]));
      chk("inc_wrap", 32'(w4), 32'(exp_w));
      chk("inc_1bit", 32'($countones(g4 ^ prev4)), 1);
    end
    inc4 = 1'b0;

    // Load 0xA then one increment
    load4 = 1'b1; lv4 = 4'hA;
    cyc();
    load4 = 1'b0;
    chk("load_bin", 32'(b4), 32'hA);
    chk("load_gray", 32'(g4), 32'hF);
    inc4 = 1'b1;
    cyc();
    inc4 = 1'b0;
    chk("load_inc_bin", 32'(b4), 32'hB);
    chk("load_inc_gray", 32'(g4), 32'hE);

    // clr beats load and inc at all-ones
    load4 = 1'b1; lv4 = 4'hF;
    cyc();
    chk("ones_bin", 32'(b4), 32'hF);
    clr4 = 1'b1; load4 = 1'b1; lv4 = 4'h7; inc4 = 1'b1;
    #1;
    chk("pri_gnxt", 32'(gn4), 0);
    cyc();
    chk("pri_clr_bin", 32'(b4), 0);
    chk("pri_clr_gray", 32'(g4), 0);
    chk("pri_clr_wrap", 32'(w4), 0);

    // load beats inc
    clr4 = 1'b0;
    cyc();
    chk("pri_load_bin", 32'(b4), 32'h7);
    chk("pri_load_gray", 32'(g4), 32'h4);
    chk("pri_load_wrap", 32'(w4), 0);
    load4 = 1'b0; inc4 = 1'b0;

    // Load all-ones then increment produces wrap
    load4 = 1'b1; lv4 = 4'hF;
    cyc();
    load4 = 1'b0; inc4 = 1'b1;
    cyc();
    inc4 = 1'b0;
    chk("loadff_wrap", 32'(w4), 1);
    chk("loadff_bin", 32'(b4), 0);
    cyc();
    chk("wrap_pulse", 32'(w4), 0);

    // Nine increments, then asynchronous reset mid-cycle
    clr4 = 1'b1;
    cyc();
    clr4 = 1'b0; inc4 = 1'b1;
    repeat (9) cyc();
    inc4 = 1'b0;
    chk("pre_rst_bin", 32'(b4), 9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_bin", 32'(b4), 0);
    chk("async_gray", 32'(g4), 0);
    chk("async_wrap", 32'(w4), 0);
    cyc();
    rst_n = 1'b1;
    inc4 = 1'b1;
    repeat (2) cyc();
    inc4 = 1'b0;
    chk("post_rst_bin", 32'(b4), 2);
    chk("post_rst_gray", 32'(g4), 3);
    m4 = 2;

    // Random mix of clr/load/inc against the arithmetic model
    for (int k = 0; k < 200; k++) begin
      clr4  = ($urandom_range(0, 9) == 0);
      load4 = ($urandom_range(0, 5) == 0);
      inc4  = ($urandom_range(0, 2) != 0);
      lv4   = 4'($urandom_range(0, 15));
      exp_w = !clr4 && !load4 && inc4 && (m4 == 15);
      if (clr4) m4 = 0;
      else if (load4) m4 = int'(lv4);
      else if (inc4) m4 = (m4 + 1) % 16;
      #1;
      chk("rnd_gnxt", 32'(gn4), 32'(gray_tbl[m4]));
      cyc();
      chk("rnd_bin", 32'(b4), 32'(m4));
      chk("rnd_gray", 32'(g4), 32'(gray_tbl[m4]));
      chk("rnd_wrap", 32'(w4), 32'(exp_w));
      chk("rnd_err", 32'(se4), 0);
    end
    clr4 = 1'b0; load4 = 1'b0; inc4 = 1'b0;

    // WIDTH=8: 600 increments interleaved with idle cycles
    chk("w8_start", 32'(b8), 0);
    m8 = 0;
    wraps8 = 0;
    for (int n = 0; n < 600; ) begin
      inc8 = ($urandom_range(0, 3) != 0);
      prev8 = g8;
      if (inc8) begin
        m8 = (m8 + 1) % 256;
        n++;
      end
      #1;
      chk("w8_gnxt", 32'(gdec8(gn8)), 32'(m8));
      cyc();
      if (w8) wraps8++;
      chk("w8_bin", 32'(b8), 32'(m8));
      chk("w8_gray", 32'(gdec8(g8)), 32'(m8));
      chk("w8_step", 32'($countones(g8 ^ prev8)), inc8 ? 1 : 0);
      chk("w8_err", 32'(se8), 0);
    end
    inc8 = 1'b0;
    cyc();
    if (w8) wraps8++;
    chk("w8_wraps", 32'(wraps8), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
